// File: rtl/dmmu_table_loader.sv
// Context-switch loader: fetches the dmmu page-table image from memory and replays it into the SR window.
// Optional abort input is enabled by defining DMMU_LDR_ABORT_EN.
module dmmu_table_loader #(
  parameter int          N_ENTRIES = 16,
  parameter logic [15:0] SR_BASE   = 16'h200,
  parameter int          LOAD_LONG = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [23:0] i_base_addr,
`ifdef DMMU_LDR_ABORT_EN
  input  logic        i_abort,
`endif
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_mem_req,
  output logic [23:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic        i_mem_err,
  input  logic [15:0] i_mem_data,
  input  logic [15:0] i_cpu_sr_addr,
  input  logic [15:0] i_cpu_sr_data,
  input  logic        i_cpu_sr_we,
  output logic [15:0] o_sr_addr,
  output logic [15:0] o_sr_data,
  output logic        o_sr_we
);

  localparam logic [4:0] LAST = 5'(N_ENTRIES - 1 + LOAD_LONG);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WR, S_DONE} state_t;

  state_t      state;
  logic [4:0]  idx;
  logic [23:0] base;
  logic [15:0] data;
  logic        err_q;
  logic        abort_pend;
  logic        abort_now;
  logic        loader_we;

`ifdef DMMU_LDR_ABORT_EN
  assign abort_now = i_abort;
`else
  assign abort_now = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      idx        <= 5'd0;
      base       <= 24'd0;
      data       <= 16'd0;
      err_q      <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (i_start) begin
            base  <= i_base_addr;
            idx   <= 5'd0;
            state <= S_REQ;
          end
        end
        // An abort during REQ never drops the handshake; it is remembered until ack/err.
        S_REQ: begin
          if (abort_now) abort_pend <= 1'b1;
          if (i_mem_err) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else if (i_mem_ack) begin
            if (abort_pend || abort_now) begin
              err_q <= 1'b1;
              state <= S_IDLE;
            end else begin
              data  <= i_mem_data;
              state <= S_WR;
            end
          end
        end
        S_WR: begin
          if (abort_now) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else if (!i_cpu_sr_we) begin
            if (idx == LAST) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 5'd1;
              state <= S_REQ;
            end
          end
        end
        S_DONE: begin
          if (abort_now) err_q <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = (state != S_IDLE);
  assign o_mem_req  = (state == S_REQ);
  assign o_mem_addr = o_mem_req ? (base + {19'd0, idx}) : 24'd0;
  assign o_done     = (state == S_DONE) && !abort_now;
  assign o_err      = err_q;
  assign loader_we  = (state == S_WR) && !abort_now;

  // CPU writes always win; the loader simply retries its write the next cycle.
  always_comb begin
    o_sr_we   = 1'b0;
    o_sr_addr = 16'd0;
    o_sr_data = 16'd0;
    if (i_cpu_sr_we) begin
      o_sr_we   = 1'b1;
      o_sr_addr = i_cpu_sr_addr;
      o_sr_data = i_cpu_sr_data;
    end else if (loader_we) begin
      o_sr_we   = 1'b1;
      o_sr_addr = SR_BASE + {11'd0, idx};
      o_sr_data = data;
    end
  end

endmodule
